// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add multiply sequencer for the EX stage
//
// Replaces the single-cycle multiplier with a BITS_PER_CYCLE-radix shift-add
// loop and holds the pipeline until the low 32 product bits are ready.
// Vectors use [0:31] ordering: bit 0 is the MSB, bit 31 the LSB.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   valid mul instruction present in EX
//   signedOp  in   1 = two's complement multiply, 0 = unsigned
//   opA       in   multiplicand [0:31]
//   opB       in   multiplier   [0:31]
//   flush     in   squash the in-flight operation
//   stall     out  freeze IF/ID/EX pipeline registers
//   busy      out  sequencer not idle
//   done      out  one-cycle pulse, product valid
//   product   out  low 32 bits of opA*opB [0:31]

module mul_sequencer #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signedOp,
  input  logic [0:31] opA,
  input  logic [0:31] opB,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [0:31] product
);

  localparam int         N        = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_LOAD = 5'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [0:31] r_mcand;
  logic [0:31] r_mplier;
  logic [0:31] r_acc;
  logic [4:0]  r_cnt;
  logic        r_neg_res;
  logic [0:31] r_product;

  logic        w_capture;
  logic        w_step;
  logic        w_last;
  logic        w_stall;
  logic [0:31] w_mag_a;
  logic [0:31] w_mag_b;
  logic [0:31] w_partial;
  logic [0:31] w_acc_nxt;

  // Signed operands are reduced to magnitudes; 0x80000000 maps to itself,
  // which is 2^31 as an unsigned value and still yields correct low bits.
  assign w_mag_a = (signedOp && opA[0]) ? (~opA + 32'd1) : opA;
  assign w_mag_b = (signedOp && opB[0]) ? (~opB + 32'd1) : opB;

  // Partial product of the multiplicand with the k multiplier LSBs,
  // built as a sum of shifted copies (bit 31 is the LSB).
  always_comb begin
    w_partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[31-i]) begin
        w_partial = w_partial + (r_mcand << i);
      end
    end
  end

  assign w_acc_nxt = r_acc + w_partial;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_capture   = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_stall = 1'b1;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == 5'd0) begin
            w_last      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_product <= '0;
    end else begin
      if (w_capture) begin
        r_mcand   <= w_mag_a;
        r_mplier  <= w_mag_b;
        r_acc     <= '0;
        r_cnt     <= CNT_LOAD;
        r_neg_res <= signedOp & (opA[0] ^ opB[0]);
      end else if (w_step) begin
        r_mcand  <= r_mcand << BITS_PER_CYCLE;
        r_mplier <= r_mplier >> BITS_PER_CYCLE;
        r_acc    <= w_acc_nxt;
        r_cnt    <= r_cnt - 5'd1;
      end
      // Result is latched on the RUN->DONE edge so it is stable through DONE.
      if (w_last) begin
        r_product <= r_neg_res ? (~w_acc_nxt + 32'd1) : w_acc_nxt;
      end
    end
  end

  // Gated by reset so the pipeline is released while reset is held.
  assign stall   = reset & w_stall;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer (radix 1, 2 and 4)

module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        stall1, busy1, done1;
  logic        stall2, busy2, done2;
  logic        stall4, busy4, done4;
  logic [31:0] prod1, prod2, prod4;

  int          n_checks = 0;
  int          n_pass   = 0;

  int          lat1, lat2, lat4;
  int          nd1, nd2, nd4;
  int          stall_cnt, stall_last;
  logic        busy_t18;
  logic [31:0] p1, p2, p4;
  logic [31:0] last_ref;

  always #5 clk = ~clk;

  mul_sequencer #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .signedOp(signed_op), .opA(op_a), .opB(op_b),
    .flush(flush), .stall(stall1), .busy(busy1), .done(done1), .product(prod1));

  mul_sequencer #(.BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .signedOp(signed_op), .opA(op_a), .opB(op_b),
    .flush(flush), .stall(stall2), .busy(busy2), .done(done2), .product(prod2));

  mul_sequencer #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .signedOp(signed_op), .opA(op_a), .opB(op_b),
    .flush(flush), .stall(stall4), .busy(busy4), .done(done4), .product(prod4));

  // Low 32 bits of the true mathematical product.
  function automatic logic [31:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint prod;
    if (s) prod = longint'($signed(a)) * longint'($signed(b));
    else   prod = longint'({32'b0, a}) * longint'({32'b0, b});
    return prod[31:0];
  endfunction

  // Called #1 after a rising edge: presents a mul for the next edge.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; signed_op = s; op_a = a; op_b = b;
  endtask

  // Runs one mul from cycle 0 (start) through cycle ncyc, recording observations.
  task automatic run_mul(input logic s, input logic [31:0] a, input logic [31:0] b, input int ncyc);
    launch(s, a, b);
    nd1 = 0; nd2 = 0; nd4 = 0; lat1 = -1; lat2 = -1; lat4 = -1;
    stall_cnt = 0; stall_last = -1; busy_t18 = 1'bx;
    #1;
    if (stall2) begin stall_cnt++; stall_last = 0; end
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (stall2) begin stall_cnt++; stall_last = c; end
      if (done1) begin nd1++; lat1 = c; p1 = prod1; end
      if (done2) begin nd2++; lat2 = c; p2 = prod2; end
      if (done4) begin nd4++; lat4 = c; p4 = prod4; end
      if (c == 18) busy_t18 = busy2;
      #1;
    end
    @(posedge clk); #1;
    last_ref = ref_mul(s, a, b);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; flush = 1'b0; signed_op = 1'b0; op_a = 32'd3; op_b = 32'd5;
    #12;
    n_checks++; if (stall2 !== 1'b0) $display("FAIL reset_stall got %b want 0", stall2); else n_pass++;
    n_checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy2); else n_pass++;
    n_checks++; if (done2 !== 1'b0) $display("FAIL reset_done got %b want 0", done2); else n_pass++;
    n_checks++; if (prod2 !== 32'h0) $display("FAIL reset_product got %h want 0", prod2); else n_pass++;
    n_checks++; if ({busy1, busy4, prod1 | prod4} !== 34'h0) $display("FAIL reset_others got %h want 0", {busy1, busy4, prod1 | prod4}); else n_pass++;
    start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_mul(1'b0, 32'd3, 32'd5, 40);
    n_checks++; if (lat2 !== 17) $display("FAIL basic_latency got %0d want 17", lat2); else n_pass++;
    n_checks++; if (nd2 !== 1) $display("FAIL basic_done_count got %0d want 1", nd2); else n_pass++;
    n_checks++; if (p2 !== 32'h0000000F) $display("FAIL basic_product got %h want 0000000f", p2); else n_pass++;
    n_checks++; if (stall_cnt !== 17) $display("FAIL basic_stall_cycles got %0d want 17", stall_cnt); else n_pass++;
    n_checks++; if (stall_last !== 16) $display("FAIL basic_stall_last got %0d want 16", stall_last); else n_pass++;
    n_checks++; if (busy_t18 !== 1'b0) $display("FAIL basic_busy_t18 got %b want 0", busy_t18); else n_pass++;
  endtask

  task automatic test_directed;
    logic [96:0] vec [6];
    logic        s;
    logic [31:0] a, b, e;
    vec = '{ {1'b0, 32'h00000003, 32'h00000005, 32'h0000000F},
             {1'b1, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6},
             {1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
             {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
             {1'b0, 32'h00010000, 32'h00010000, 32'h00000000},
             {1'b1, 32'h80000000, 32'h80000000, 32'h00000000} };
    for (int i = 0; i < 6; i++) begin
      {s, a, b, e} = vec[i];
      run_mul(s, a, b, 40);
      n_checks++; if (p2 !== e) $display("FAIL directed%0d_r2 got %h want %h", i, p2, e); else n_pass++;
      n_checks++; if (p1 !== e) $display("FAIL directed%0d_r1 got %h want %h", i, p1, e); else n_pass++;
      n_checks++; if (p4 !== e) $display("FAIL directed%0d_r4 got %h want %h", i, p4, e); else n_pass++;
      n_checks++; if (lat1 !== 33) $display("FAIL directed%0d_lat1 got %0d want 33", i, lat1); else n_pass++;
      n_checks++; if (lat4 !== 9) $display("FAIL directed%0d_lat4 got %0d want 9", i, lat4); else n_pass++;
      n_checks++; if ({nd1, nd4} !== {32'd1, 32'd1}) $display("FAIL directed%0d_dones got %0d,%0d want 1,1", i, nd1, nd4); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic        s;
    logic [31:0] a, b, e;
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      a = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      b = (i % 4 == 1) ? (32'hFFFFFF00 | 32'($urandom_range(0, 255))) : $urandom;
      e = ref_mul(s, a, b);
      run_mul(s, a, b, 40);
      n_checks++; if (p2 !== e) $display("FAIL random%0d_r2 a=%h b=%h s=%b got %h want %h", i, a, b, s, p2, e); else n_pass++;
      n_checks++; if (p1 !== e) $display("FAIL random%0d_r1 got %h want %h", i, p1, e); else n_pass++;
      n_checks++; if (p4 !== e) $display("FAIL random%0d_r4 got %h want %h", i, p4, e); else n_pass++;
      n_checks++; if (lat2 !== 17) $display("FAIL random%0d_lat2 got %0d want 17", i, lat2); else n_pass++;
    end
  endtask

  task automatic test_flush;
    logic [31:0] prev, a2, b2, e2;
    int          early_done, prod_bad;
    logic        done_t24;
    logic [31:0] prod_t24;
    prev = last_ref; early_done = 0; prod_bad = 0;
    a2 = $urandom; b2 = $urandom; e2 = ref_mul(1'b1, a2, b2);
    launch(1'b0, $urandom, $urandom);
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 5) flush = 1'b1;
      if (c == 6) flush = 1'b0;
      if (c == 7) launch(1'b1, a2, b2);
      if (c == 8) start = 1'b0;
      #1;
      if (c == 6) begin
        n_checks++; if (busy2 !== 1'b0) $display("FAIL flush_busy got %b want 0", busy2); else n_pass++;
        n_checks++; if (stall2 !== 1'b0) $display("FAIL flush_stall got %b want 0", stall2); else n_pass++;
      end
      if (c <= 23 && done2) early_done++;
      if (c <= 23 && prod2 !== prev) prod_bad++;
      if (c == 24) begin done_t24 = done2; prod_t24 = prod2; end
    end
    n_checks++; if (early_done !== 0) $display("FAIL flush_no_done got %0d want 0", early_done); else n_pass++;
    n_checks++; if (prod_bad !== 0) $display("FAIL flush_product_held got %0d bad cycles want 0", prod_bad); else n_pass++;
    n_checks++; if (done_t24 !== 1'b1) $display("FAIL flush_restart_done got %b want 1", done_t24); else n_pass++;
    n_checks++; if (prod_t24 !== e2) $display("FAIL flush_restart_product got %h want %h", prod_t24, e2); else n_pass++;
    last_ref = e2;
    @(posedge clk); #1;
  endtask

  task automatic test_flush_start_idle;
    int ndone;
    ndone = 0;
    launch(1'b0, 32'h12345678, 32'h9ABCDEF0);
    flush = 1'b1;
    #1;
    n_checks++; if (stall2 !== 1'b0) $display("FAIL flushstart_stall got %b want 0", stall2); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_checks++; if ({busy1, busy2, busy4} !== 3'b000) $display("FAIL flushstart_busy got %b want 000", {busy1, busy2, busy4}); else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done1 || done2 || done4) ndone++;
    end
    n_checks++; if (ndone !== 0) $display("FAIL flushstart_no_done got %0d want 0", ndone); else n_pass++;
    n_checks++; if (prod2 !== last_ref) $display("FAIL flushstart_product got %h want %h", prod2, last_ref); else n_pass++;
  endtask

  task automatic test_async_reset;
    int ndone;
    ndone = 0;
    launch(1'b0, 32'hDEADBEEF, 32'h00000FFF);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({stall2, busy2, done2} !== 3'b000) $display("FAIL areset_ctrl got %b want 000", {stall2, busy2, done2}); else n_pass++;
    n_checks++; if (prod2 !== 32'h0) $display("FAIL areset_product got %h want 0", prod2); else n_pass++;
    n_checks++; if ({busy1, busy4, stall1, stall4} !== 4'b0000) $display("FAIL areset_others got %b want 0000", {busy1, busy4, stall1, stall4}); else n_pass++;
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done1 || done2 || done4) ndone++;
    end
    n_checks++; if (ndone !== 0) $display("FAIL areset_no_done got %0d want 0", ndone); else n_pass++;
    last_ref = 32'h0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2, e1, e2;
    logic [31:0] got [2];
    int          at [2];
    int          ndone2, ndone1, ndone4;
    logic        stall_t18;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = ref_mul(1'b1, a1, b1); e2 = ref_mul(1'b0, a2, b2);
    ndone1 = 0; ndone2 = 0; ndone4 = 0; at = '{-1, -1}; got = '{32'h0, 32'h0};
    launch(1'b1, a1, b1);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1 || c == 19) start = 1'b0;
      if (c == 18) launch(1'b0, a2, b2);
      #1;
      if (c == 18) stall_t18 = stall2;
      if (done2) begin
        if (ndone2 < 2) begin got[ndone2] = prod2; at[ndone2] = c; end
        ndone2++;
      end
      if (done1) ndone1++;
      if (done4) ndone4++;
    end
    n_checks++; if (stall_t18 !== 1'b1) $display("FAIL b2b_stall_second got %b want 1", stall_t18); else n_pass++;
    n_checks++; if (ndone2 !== 2) $display("FAIL b2b_done_count got %0d want 2", ndone2); else n_pass++;
    n_checks++; if (at[0] !== 17) $display("FAIL b2b_first_latency got %0d want 17", at[0]); else n_pass++;
    n_checks++; if (got[0] !== e1) $display("FAIL b2b_first_product got %h want %h", got[0], e1); else n_pass++;
    n_checks++; if (at[1] !== 35) $display("FAIL b2b_second_latency got %0d want 35", at[1]); else n_pass++;
    n_checks++; if (got[1] !== e2) $display("FAIL b2b_second_product got %h want %h", got[1], e2); else n_pass++;
    n_checks++; if ({ndone1, ndone4} !== {32'd1, 32'd2}) $display("FAIL b2b_radix_dones got %0d,%0d want 1,2", ndone1, ndone4); else n_pass++;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; signed_op = 1'b0; flush = 1'b0;
    op_a = 32'h0; op_b = 32'h0; last_ref = 32'h0;
    test_reset;
    test_basic;
    test_directed;
    test_random;
    test_flush;
    test_flush_start_idle;
    test_async_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
